// File: rtl/ps2_key_pkg.sv
// Shared scan-code constants, key indices and decoder state for ps2_key_events.
// Key map helper turns a set-2 code byte into a one-hot {ESC,R,DOWN,UP} mask.
package ps2_key_pkg;

    localparam logic [7:0] SC_EXT  = 8'hE0;
    localparam logic [7:0] SC_BRK  = 8'hF0;
    localparam logic [7:0] SC_UP   = 8'h75;
    localparam logic [7:0] SC_DOWN = 8'h72;
    localparam logic [7:0] SC_R    = 8'h2D;
    localparam logic [7:0] SC_ESC  = 8'h76;

    localparam int KEY_UP   = 0;
    localparam int KEY_DOWN = 1;
    localparam int KEY_R    = 2;
    localparam int KEY_ESC  = 3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXT     = 2'd1,
        ST_BRK     = 2'd2,
        ST_EXT_BRK = 2'd3
    } dec_state_t;

    // UP/DOWN ignore the E0 prefix so keypad 8/2 also steer the dino.
    function automatic logic [3:0] key_map(
        input logic [7:0] b,
        input logic       ext
    );
        logic [3:0] m;
        m           = '0;
        m[KEY_UP]   = (b == SC_UP);
        m[KEY_DOWN] = (b == SC_DOWN);
        m[KEY_R]    = (b == SC_R) && !ext;
        m[KEY_ESC]  = (b == SC_ESC) && !ext;
        return m;
    endfunction

endpackage

// File: rtl/ps2_strobe_sync.sv
// Two-flop synchronizer plus edge register for the PS2_driver byte-ready level.
// stb is high for one clk cycle per rising edge of the asynchronous input.
module ps2_strobe_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic stb
);

    logic [2:0] s;

    // Shift the raw level through sync stages s[0], s[1] and edge stage s[2].
    always_ff @(posedge clk) begin
        if (!rst) s <= '0;
        else      s <= {s[1:0], d};
    end

    assign stb = s[1] & ~s[2];

endmodule

// File: rtl/ps2_key_events.sv
// Set-2 scan-code decoder: E0/F0 prefixes, held levels and make pulses for UP/DOWN/R/ESC.
// Define KEY_REPEAT_PULSE_EN to let typematic repeats of a held key fire key_press too.
module ps2_key_events
    import ps2_key_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 2_000_000,
    parameter int TMO_W          = 21
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_state,
    input  logic [7:0] ps2_byte,
    output logic [3:0] key_held,
    output logic [3:0] key_press,
    output logic       any_press,
    output logic       seq_error
);

    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    logic             stb;
    logic             stb_q;
    logic [7:0]       byte_q;
    dec_state_t       state;
    dec_state_t       state_nxt;
    logic [TMO_W-1:0] tmo_cnt;
    logic [TMO_W-1:0] tmo_nxt;
    logic [3:0]       held_nxt;
    logic [3:0]       press_nxt;
    logic             any_nxt;
    logic             err_nxt;
    logic             do_make;
    logic             do_brk;
    logic             ext;
    logic [3:0]       kmask;

    ps2_strobe_sync u_sync (
        .clk (clk),
        .rst (rst),
        .d   (ps2_state),
        .stb (stb)
    );

    // Capture the byte alongside the strobe; the decoder acts one cycle later.
    always_ff @(posedge clk) begin
        if (!rst) begin
            stb_q  <= 1'b0;
            byte_q <= '0;
        end else begin
            stb_q  <= stb;
            if (stb) byte_q <= ps2_byte;
        end
    end

    // Decoder next state, prefix timeout and key event generation.
    always_comb begin
        state_nxt = state;
        tmo_nxt   = tmo_cnt;
        held_nxt  = key_held;
        press_nxt = '0;
        any_nxt   = 1'b0;
        err_nxt   = 1'b0;
        do_make   = 1'b0;
        do_brk    = 1'b0;
        ext       = (state == ST_EXT) || (state == ST_EXT_BRK);
        kmask     = key_map(byte_q, ext);

        if (stb_q) begin
            tmo_nxt = '0;
            unique case (state)
                ST_IDLE: begin
                    if (byte_q == SC_EXT)      state_nxt = ST_EXT;
                    else if (byte_q == SC_BRK) state_nxt = ST_BRK;
                    else                       do_make   = 1'b1;
                end
                ST_EXT: begin
                    if (byte_q == SC_BRK) begin
                        state_nxt = ST_EXT_BRK;
                    end else if (byte_q == SC_EXT) begin
                        err_nxt = 1'b1;
                    end else begin
                        do_make   = 1'b1;
                        state_nxt = ST_IDLE;
                    end
                end
                ST_BRK, ST_EXT_BRK: begin
                    state_nxt = ST_IDLE;
                    if (byte_q == SC_EXT || byte_q == SC_BRK) err_nxt = 1'b1;
                    else                                      do_brk  = 1'b1;
                end
            endcase
        end else if (state != ST_IDLE) begin
            if (tmo_cnt == TMO_LAST) begin
                err_nxt   = 1'b1;
                state_nxt = ST_IDLE;
                tmo_nxt   = '0;
            end else begin
                tmo_nxt = tmo_cnt + 1'b1;
            end
        end

        if (do_make) begin
            any_nxt = 1'b1;
`ifdef KEY_REPEAT_PULSE_EN
            press_nxt = kmask;
`else
            press_nxt = kmask & ~key_held;
`endif
            held_nxt = key_held | kmask;
        end
        if (do_brk) held_nxt = key_held & ~kmask;
    end

    // State, timeout counter and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= ST_IDLE;
            tmo_cnt   <= '0;
            key_held  <= '0;
            key_press <= '0;
            any_press <= 1'b0;
            seq_error <= 1'b0;
        end else begin
            state     <= state_nxt;
            tmo_cnt   <= tmo_nxt;
            key_held  <= held_nxt;
            key_press <= press_nxt;
            any_press <= any_nxt;
            seq_error <= err_nxt;
        end
    end

endmodule

// File: tb/tb_ps2_key_events.sv
// Bench for ps2_key_events: directed table, latency/timeout/reset sequences, random bytes.
// Random bytes are checked against a prefix-flag model of the scan-code rules.
module tb_ps2_key_events;

`ifdef KEY_REPEAT_PULSE_EN
    localparam bit REP = 1'b1;
`else
    localparam bit REP = 1'b0;
`endif

    localparam int TMO = 100;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       ps2_state = 1'b0;
    logic [7:0] ps2_byte = 8'h00;
    logic [3:0] key_held;
    logic [3:0] key_press;
    logic       any_press;
    logic       seq_error;

    int n_pass = 0;
    int n_total = 0;

    logic [3:0] win_press_or;
    int         win_press_n;
    int         win_any;
    int         win_err;

    // model state: pending prefix flags and held keys
    bit         m_ext;
    bit         m_brk;
    logic [3:0] m_held;

    typedef struct {
        logic [7:0] b;
        logic [3:0] held;
        logic [3:0] press;
        logic       any;
        logic       err;
    } vec_t;

    vec_t vecs[$];

    ps2_key_events #(
        .TIMEOUT_CYCLES (TMO),
        .TMO_W          (7)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ps2_state (ps2_state),
        .ps2_byte  (ps2_byte),
        .key_held  (key_held),
        .key_press (key_press),
        .any_press (any_press),
        .seq_error (seq_error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        win_press_or = win_press_or | key_press;
        win_press_n  = win_press_n + $countones(key_press);
        win_any      = win_any + int'(any_press);
        win_err      = win_err + int'(seq_error);
    end

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        win_press_or = '0;
        win_press_n  = 0;
        win_any      = 0;
        win_err      = 0;
        ps2_byte     = b;
        ps2_state    = 1'b1;
        repeat (8) @(negedge clk);
        ps2_state = 1'b0;
        repeat (20) @(negedge clk);
    endtask

    // packed result: held, press mask, press count, any count, err count
    function automatic logic [31:0] pack(input logic [3:0] h, input logic [3:0] p,
                                         input int pn, input int a, input int e);
        return {12'h0, h, p, 4'(pn), 4'(a), 4'(e)};
    endfunction

    task automatic send_check(input string name, input logic [7:0] b,
                              input logic [3:0] h, input logic [3:0] p,
                              input logic a, input logic e);
        send_byte(b);
        check(name, pack(key_held, win_press_or, win_press_n, win_any, win_err),
              pack(h, p, $countones(p), int'(a), int'(e)));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    function automatic int key_idx(input logic [7:0] b, input bit ext);
        if (b == 8'h75) return 0;
        if (b == 8'h72) return 1;
        if (b == 8'h2D && !ext) return 2;
        if (b == 8'h76 && !ext) return 3;
        return -1;
    endfunction

    task automatic model_byte(input logic [7:0] b, output logic [3:0] p,
                              output logic a, output logic e);
        int k;
        p = '0;
        a = 1'b0;
        e = 1'b0;
        if (b == 8'hE0) begin
            if (m_brk) begin e = 1'b1; m_ext = 0; m_brk = 0; end
            else if (m_ext) e = 1'b1;
            else m_ext = 1;
        end else if (b == 8'hF0) begin
            if (m_brk) begin e = 1'b1; m_ext = 0; m_brk = 0; end
            else m_brk = 1;
        end else begin
            k = key_idx(b, m_ext);
            if (m_brk) begin
                if (k >= 0) m_held[k] = 1'b0;
            end else begin
                a = 1'b1;
                if (k >= 0) begin
                    if (!m_held[k] || REP) p[k] = 1'b1;
                    m_held[k] = 1'b1;
                end
            end
            m_ext = 0;
            m_brk = 0;
        end
    endtask

    function automatic void add(input logic [7:0] b, input logic [3:0] h,
                                input logic [3:0] p, input logic a, input logic e);
        vec_t v;
        v.b = b; v.held = h; v.press = p; v.any = a; v.err = e;
        vecs.push_back(v);
    endfunction

    initial begin
        logic [3:0] ep;
        logic       ea;
        logic       ee;
        int         hit;
        logic [7:0] rb;

        // reset state
        repeat (3) @(negedge clk);
        check("reset_outputs", {25'h0, key_held, key_press, any_press, seq_error}, 32'h0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // make latency: pulse exactly after the 4th edge
        ps2_byte  = 8'h2D;
        ps2_state = 1'b1;
        repeat (3) @(posedge clk);
        #1 check("lat_edge3", {28'h0, key_press}, 32'h0);
        @(posedge clk);
        #1 check("lat_edge4", {27'h0, key_press, any_press}, {27'h0, 4'b0100, 1'b1});
        @(posedge clk);
        #1 check("lat_edge5", {27'h0, key_press, any_press}, 32'h0);
        check("lat_held", {28'h0, key_held}, 32'h4);
        @(negedge clk);
        repeat (3) @(negedge clk);
        ps2_state = 1'b0;
        repeat (20) @(negedge clk);

        // directed table
        add(8'hF0, 4'b0100, 4'b0000, 0, 0);
        add(8'h2D, 4'b0000, 4'b0000, 0, 0);
        add(8'hE0, 4'b0000, 4'b0000, 0, 0);
        add(8'h75, 4'b0001, 4'b0001, 1, 0);
        add(8'hE0, 4'b0001, 4'b0000, 0, 0);
        add(8'h75, 4'b0001, REP ? 4'b0001 : 4'b0000, 1, 0);
        add(8'hE0, 4'b0001, 4'b0000, 0, 0);
        add(8'h75, 4'b0001, REP ? 4'b0001 : 4'b0000, 1, 0);
        add(8'hE0, 4'b0001, 4'b0000, 0, 0);
        add(8'hF0, 4'b0001, 4'b0000, 0, 0);
        add(8'h75, 4'b0000, 4'b0000, 0, 0);
        add(8'hE0, 4'b0000, 4'b0000, 0, 0);
        add(8'h72, 4'b0010, 4'b0010, 1, 0);
        add(8'h76, 4'b1010, 4'b1000, 1, 0);
        add(8'hF0, 4'b1010, 4'b0000, 0, 0);
        add(8'h76, 4'b0010, 4'b0000, 0, 0);
        add(8'hE0, 4'b0010, 4'b0000, 0, 0);
        add(8'hF0, 4'b0010, 4'b0000, 0, 0);
        add(8'h72, 4'b0000, 4'b0000, 0, 0);
        add(8'h1C, 4'b0000, 4'b0000, 1, 0);
        add(8'hE0, 4'b0000, 4'b0000, 0, 0);
        add(8'hE0, 4'b0000, 4'b0000, 0, 1);
        add(8'h75, 4'b0001, 4'b0001, 1, 0);
        add(8'hE0, 4'b0001, 4'b0000, 0, 0);
        add(8'h2D, 4'b0001, 4'b0000, 1, 0);
        add(8'hF0, 4'b0001, 4'b0000, 0, 0);
        add(8'hE0, 4'b0001, 4'b0000, 0, 1);
        add(8'hE1, 4'b0001, 4'b0000, 1, 0);
        add(8'hF0, 4'b0001, 4'b0000, 0, 0);
        add(8'h75, 4'b0000, 4'b0000, 0, 0);
        foreach (vecs[i])
            send_check($sformatf("vec%0d_%h", i, vecs[i].b), vecs[i].b,
                       vecs[i].held, vecs[i].press, vecs[i].any, vecs[i].err);

        // prefix timeout: F0 then silence
        @(negedge clk);
        ps2_byte  = 8'hF0;
        ps2_state = 1'b1;
        hit = 0;
        for (int n = 1; n <= 300; n++) begin
            @(posedge clk);
            #1;
            if (n == 8) ps2_state = 1'b0;
            if (seq_error) begin
                hit = n;
                break;
            end
        end
        check("tmo_edge", 32'(hit), 32'(4 + TMO));
        @(posedge clk);
        #1 check("tmo_pulse_len", {31'h0, seq_error}, 32'h0);
        repeat (20) @(negedge clk);
        send_check("tmo_then_make", 8'h2D, 4'b0100, 4'b0100, 1, 0);

        // reset mid-sequence
        send_check("pre_rst_esc", 8'h76, 4'b1100, 4'b1000, 1, 0);
        send_byte(8'hE0);
        do_reset();
        check("rst_mid_outputs", {25'h0, key_held, key_press, any_press, seq_error}, 32'h0);
        send_check("rst_then_up", 8'h75, 4'b0001, 4'b0001, 1, 0);

        // randomized bytes against the model
        do_reset();
        m_ext  = 0;
        m_brk  = 0;
        m_held = '0;
        for (int i = 0; i < 150; i++) begin
            case ($urandom_range(0, 9))
                0, 1:    rb = 8'hE0;
                2:       rb = 8'hF0;
                3:       rb = 8'h75;
                4:       rb = 8'h72;
                5:       rb = 8'h2D;
                6:       rb = 8'h76;
                default: rb = 8'($urandom_range(0, 255));
            endcase
            model_byte(rb, ep, ea, ee);
            send_check($sformatf("rnd%0d_%h", i, rb), rb, m_held, ep, ea, ee);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
